// File: rtl/alu_cmd_issuer.sv
// Issue stage for the 8-bit ALU: command FIFO, one-at-a-time ALU sequencing, in-order responses.
// Define ALU_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT_CYCLES cycles with rsp_err=1.
module alu_cmd_issuer #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [7:0]              cmd_a,
  input  logic [7:0]              cmd_b,
  input  logic [2:0]              cmd_op,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [15:0]             rsp_result,
  output logic [2:0]              rsp_op,
  output logic                    rsp_err,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [7:0]              alu_a,
  output logic [7:0]              alu_b,
  output logic [2:0]              alu_opcode,
  output logic                    alu_start,
  input  logic [15:0]             alu_result,
  input  logic                    alu_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_next;

  // FIFO entry layout: {op, b, a}
  logic [18:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [18:0]   head;
  logic          push, pop, timeout, alu_fin, enter_resp;

  assign head       = mem[rd_ptr];
  assign cmd_ready  = (count != CW'(DEPTH));
  assign push       = cmd_valid & cmd_ready;
  assign fifo_count = count;
  assign rsp_valid  = (state == RESP);
  assign alu_start  = (state == ISSUE);
  assign alu_fin    = (state == WAIT) & (alu_done | timeout);
  assign enter_resp = (pop & (head[18:16] == 3'd0)) | alu_fin;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_op, cmd_b, cmd_a};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= AW'(0);
      rd_ptr <= AW'(0);
      count  <= CW'(0);
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != CW'(0)) begin
          pop        = 1'b1;
          state_next = (head[18:16] == 3'd0) ? RESP : ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (alu_done | timeout) state_next = RESP;
        else                    state_next = WAIT;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
        else           state_next = RESP;
      end
      default: state_next = IDLE;
    endcase
  end

  // ALU pins move only on a pop; response fields load as RESP is entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_opcode <= 3'd0;
      rsp_result <= 16'h0000;
      rsp_op     <= 3'd0;
    end else begin
      if (pop) begin
        alu_a      <= head[7:0];
        alu_b      <= head[15:8];
        alu_opcode <= head[18:16];
      end
      if (pop & (head[18:16] == 3'd0)) begin
        rsp_result <= 16'h0000;
        rsp_op     <= 3'd0;
      end else if (alu_fin) begin
        rsp_result <= alu_done ? alu_result : 16'h0000;
        rsp_op     <= alu_opcode;
      end
    end
  end

`ifdef ALU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;

  // Counts WAIT cycles; zero outside WAIT so it restarts on every entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                wait_cnt <= TW'(0);
    else if (state != WAIT) wait_cnt <= TW'(0);
    else                    wait_cnt <= wait_cnt + TW'(1);
  end

  assign timeout = (state == WAIT) & ~alu_done & (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             rsp_err <= 1'b0;
    else if (enter_resp) rsp_err <= timeout;
    else                 rsp_err <= rsp_err;
  end
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: behavioural ALU, scoreboard of expected responses, latency checks.
module tb_alu_cmd_issuer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_a = 8'h00, cmd_b = 8'h00;
  logic [2:0]  cmd_op = 3'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_err;
  logic [2:0]  fifo_count;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_opcode;
  logic        alu_start;
  logic [15:0] alu_result;
  logic        alu_done;

  alu_cmd_issuer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_err(rsp_err),
    .fifo_count(fifo_count),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_start(alu_start),
    .alu_result(alu_result), .alu_done(alu_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: single-cycle ops finish the cycle after start, MUL after mul_lat cycles
  logic        m_busy = 1'b0;
  logic [3:0]  m_left = 4'd0;
  logic [15:0] m_res = 16'h0000;
  logic [7:0]  h_a = 8'h00, h_b = 8'h00;
  logic [2:0]  h_op = 3'd0;
  logic        alu_stub = 1'b0;
  int          mul_lat = 3;
  int          starts = 0;

  assign alu_done   = m_busy && (m_left == 4'd0) && !alu_stub;
  assign alu_result = m_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_left <= 4'd0;
      m_res  <= 16'h0000;
    end else if (alu_start) begin
      m_busy <= 1'b1;
      h_a    <= alu_a;
      h_b    <= alu_b;
      h_op   <= alu_opcode;
      starts <= starts + 1;
      m_left <= (alu_opcode >= 3'd4) ? 4'(mul_lat - 1) : 4'd0;
      case (alu_opcode)
        3'd1:    m_res <= {8'h00, alu_a} + {8'h00, alu_b};
        3'd2:    m_res <= {8'h00, alu_a & alu_b};
        3'd3:    m_res <= {8'h00, alu_a ^ alu_b};
        default: m_res <= {8'h00, alu_a} * {8'h00, alu_b};
      endcase
    end else if (m_busy) begin
      if (m_left == 4'd0) m_busy <= 1'b0;
      else                m_left <= m_left - 4'd1;
    end
  end

  typedef struct {
    logic [15:0] result;
    logic [2:0]  op;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   rsp_seen = 0;
  int   hs_cyc = 0;

  logic        sv_valid = 1'b0;
  logic [15:0] sv_result = 16'h0000;
  logic [2:0]  sv_op = 3'd0;
  logic        sv_err = 1'b0;
  logic        prev_start = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: evaluate the handshake of the edge just passed, then snapshot outputs for the next one
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (sv_valid && rsp_ready) begin
      chk("rsp_expected", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_result", sv_result, e.result);
        chk("rsp_op", sv_op, e.op);
        chk("rsp_err", sv_err, e.err);
        rsp_seen++;
      end
    end
    if (m_busy) begin
      chk("alu_a_hold", alu_a, h_a);
      chk("alu_b_hold", alu_b, h_b);
      chk("alu_op_hold", alu_opcode, h_op);
    end
    if (prev_start) chk("start_single_pulse", alu_start, 0);
    sv_valid   = rsp_valid;
    sv_result  = rsp_result;
    sv_op      = rsp_op;
    sv_err     = rsp_err;
    prev_start = alu_start;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [15:0] res, input logic err);
    int   w = 0;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    while (!cmd_ready && w < 400) begin
      step();
      w++;
    end
    chk("cmd_accept", cmd_ready, 1);
    if (cmd_ready) begin
      hs_cyc   = cyc;
      e.result = res;
      e.op     = op;
      e.err    = err;
      sb.push_back(e);
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int lat, input string tag);
    int w = 0;
    while (!rsp_valid && w < 200) begin
      step();
      w++;
    end
    chk(tag, cyc - hs_cyc, lat);
  endtask

  task automatic drain(input string tag);
    int w = 0;
    while (sb.size() != 0 && w < 2000) begin
      step();
      w++;
    end
    chk(tag, sb.size(), 0);
    step();
    step();
  endtask

  task automatic check_reset(input string p);
    chk({p, "_cmd_ready"}, cmd_ready, 1);
    chk({p, "_rsp_valid"}, rsp_valid, 0);
    chk({p, "_rsp_result"}, rsp_result, 0);
    chk({p, "_rsp_op"}, rsp_op, 0);
    chk({p, "_rsp_err"}, rsp_err, 0);
    chk({p, "_fifo_count"}, fifo_count, 0);
    chk({p, "_alu_a"}, alu_a, 0);
    chk({p, "_alu_b"}, alu_b, 0);
    chk({p, "_alu_opcode"}, alu_opcode, 0);
    chk({p, "_alu_start"}, alu_start, 0);
  endtask

  initial begin
    int s0;
    int seen0;

    step();
    step();
    check_reset("por");
    rst = 1'b0;
    step();

    // ADD with carry out, latency N+4
    send(8'hFF, 8'h01, 3'd1, 16'h0100, 1'b0);
    chk("fifo_count_one", fifo_count, 1);
    wait_rsp(4, "add_latency");
    drain("add_drain");

    // AND then XOR back-to-back, in order
    send(8'hF0, 8'h3C, 3'd2, 16'h0030, 1'b0);
    send(8'hF0, 8'h3C, 3'd3, 16'h00CC, 1'b0);
    drain("and_xor_drain");

    // NOP bypasses the ALU, latency N+2
    s0 = starts;
    send(8'h12, 8'h34, 3'd0, 16'h0000, 1'b0);
    wait_rsp(2, "nop_latency");
    drain("nop_drain");
    chk("nop_no_start", starts - s0, 0);

    // MUL multi-cycle, latency N+3+mul_lat
    s0 = starts;
    mul_lat = 3;
    send(8'h0F, 8'h0F, 3'd4, 16'h00E1, 1'b0);
    wait_rsp(6, "mul_latency");
    drain("mul_drain");
    chk("mul_one_start", starts - s0, 1);

    // Stall responses and overfill the queue
    seen0 = rsp_seen;
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      send(8'(i), 8'h10, 3'd1, 16'(i + 16), 1'b0);
    end
    step();
    step();
    chk("full_cmd_ready", cmd_ready, 0);
    chk("full_fifo_count", fifo_count, DEPTH);
    cmd_valid = 1'b1;
    cmd_a = 8'hAA;
    cmd_b = 8'hBB;
    cmd_op = 3'd3;
    step();
    step();
    cmd_valid = 1'b0;
    chk("full_no_accept", fifo_count, DEPTH);
    rsp_ready = 1'b1;
    drain("full_drain");
    chk("full_rsp_count", rsp_seen - seen0, DEPTH + 1);
    chk("full_empty_after", fifo_count, 0);

    // Reset while WAITing on a long multiply
    mul_lat = 8;
    send(8'h20, 8'h03, 3'd5, 16'h0060, 1'b0);
    step();
    step();
    step();
    chk("mid_in_wait_opcode", alu_opcode, 5);
    rst = 1'b1;
    #1;
    check_reset("mid");
    sb.delete();
    s0 = starts;
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("mid_no_stale_rsp", rsp_valid, 0);
    chk("mid_no_restart", starts - s0, 0);

    // Recovery after reset
    mul_lat = 3;
    send(8'h55, 8'h0F, 3'd3, 16'h005A, 1'b0);
    drain("recover_drain");

`ifdef ALU_TIMEOUT_EN
    alu_stub = 1'b1;
    send(8'h01, 8'h02, 3'd1, 16'h0000, 1'b1);
    wait_rsp(3 + 64, "timeout_latency");
    drain("timeout_drain");
    alu_stub = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
